// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes,
// sequencer states and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01
    } state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward selector: compares one EX source register against the
// EX/MEM and MEM/WB destinations; the younger EX/MEM result has priority.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_src,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_t          sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is constant zero, so a write to it must never be forwarded
    assign mem_hit = mem_valid && mem_regwrite && (mem_rd != REG_AW'(REG_ZERO)) && (mem_rd == ex_src);
    assign wb_hit  = wb_valid && wb_regwrite && (wb_rd != REG_AW'(REG_ZERO)) && (wb_rd == ex_src);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: operand forwarding, load-use stall,
// taken-branch flush and whole-pipe freeze on dmem wait.
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
//
// state       | meaning
// ST_RUN      | pipe flows; load-use / branch hazards resolved here
// ST_MEM_WAIT | MEM-stage dmem access outstanding, whole pipe frozen
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memreq,
    input  logic              ex_branch_taken,
    input  logic              dmem_ready,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall_front,
    output logic              stall_back,
    output logic              flush_if_id,
    output logic              flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    // Later stages keep only the fields that are still consumed downstream
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memreq;
    } ex_shadow_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memreq;
    } mem_shadow_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } wb_shadow_t;

    ex_shadow_t  ex_s;
    mem_shadow_t mem_s;
    wb_shadow_t  wb_s;
    state_t      state;

    fwd_sel_t    sel_a;
    fwd_sel_t    sel_b;
    logic        mem_pending;
    logic        stall_mem;
    logic        load_use;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_src       (ex_s.rs1),
        .mem_valid    (mem_s.valid),
        .mem_regwrite (mem_s.regwrite),
        .mem_rd       (mem_s.rd),
        .wb_valid     (wb_s.valid),
        .wb_regwrite  (wb_s.regwrite),
        .wb_rd        (wb_s.rd),
        .sel          (sel_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_src       (ex_s.rs2),
        .mem_valid    (mem_s.valid),
        .mem_regwrite (mem_s.regwrite),
        .mem_rd       (mem_s.rd),
        .wb_valid     (wb_s.valid),
        .wb_regwrite  (wb_s.regwrite),
        .wb_rd        (wb_s.rd),
        .sel          (sel_b)
    );

    assign forward_a = sel_a;
    assign forward_b = sel_b;

    assign mem_pending = mem_s.valid && mem_s.memreq && !dmem_ready;

    // The RUN cycle that discovers the wait already freezes the pipe
    always_comb begin
        stall_mem = mem_pending;
        if (state == ST_MEM_WAIT) begin
            stall_mem = !dmem_ready;
        end
    end

    assign load_use = ex_s.valid && ex_s.memread && (ex_s.rd != REG_AW'(REG_ZERO)) && id_valid
                   && ((id_use_rs1 && (id_rs1 == ex_s.rd)) || (id_use_rs2 && (id_rs2 == ex_s.rd)));

    // A taken branch kills the ID instruction, so any load-use stall is moot
    assign stall_front = stall_mem || (load_use && !ex_branch_taken);
    assign stall_back  = stall_mem;
    assign flush_if_id = !stall_mem && ex_branch_taken;
    assign flush_id_ex = !stall_mem && (ex_branch_taken || load_use);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:      if (mem_pending) state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (dmem_ready)  state <= ST_RUN;
                default:                      state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
        end else if (!stall_back) begin
            if (flush_id_ex) begin
                ex_s <= '0;
            end else begin
                ex_s <= '{valid:    id_valid,
                          rs1:      id_rs1,
                          rs2:      id_rs2,
                          rd:       id_rd,
                          regwrite: id_regwrite,
                          memread:  id_memread,
                          memreq:   id_memreq};
            end
            mem_s <= '{valid:    ex_s.valid,
                       rd:       ex_s.rd,
                       regwrite: ex_s.regwrite,
                       memreq:   ex_s.memreq};
            wb_s  <= '{valid:    mem_s.valid,
                       rd:       mem_s.rd,
                       regwrite: mem_s.regwrite};
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counters: a wrapped count would read as a near-idle core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((stall_front || stall_back) && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (flush_if_id && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table plus hand-written
// mem-wait and reset sequences; counter checks when HAZARD_PERF_CNT_EN is set.
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2;
    logic              id_regwrite, id_memread, id_memreq;
    logic              ex_branch_taken, dmem_ready;
    logic [1:0]        forward_a, forward_b;
    logic              stall_front, stall_back, flush_if_id, flush_id_ex;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;
`endif

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .id_memreq       (id_memreq),
        .ex_branch_taken (ex_branch_taken),
        .dmem_ready      (dmem_ready),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .stall_front     (stall_front),
        .stall_back      (stall_back),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       iv;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr, mq, br, rdy;
        logic [1:0] fa, fb;
        logic       sf, sb, fie, fix;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    function automatic vec_t mk(string name, logic iv, int rs1, int rs2, logic u1, logic u2, int rd,
                                logic rw, logic mr, logic mq, logic br, logic rdy,
                                logic [1:0] fa, logic [1:0] fb, logic sf, logic sb, logic fie, logic fix);
        vec_t v;
        v.name = name; v.iv = iv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = 5'(rd); v.rw = rw; v.mr = mr; v.mq = mq; v.br = br; v.rdy = rdy;
        v.fa = fa; v.fb = fb; v.sf = sf; v.sb = sb; v.fie = fie; v.fix = fix;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.iv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        id_rd = v.rd; id_regwrite = v.rw; id_memread = v.mr; id_memreq = v.mq;
        ex_branch_taken = v.br; dmem_ready = v.rdy;
    endtask

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t v);
        chk(v.name, "forward_a",   32'(forward_a),   32'(v.fa));
        chk(v.name, "forward_b",   32'(forward_b),   32'(v.fb));
        chk(v.name, "stall_front", 32'(stall_front), 32'(v.sf));
        chk(v.name, "stall_back",  32'(stall_back),  32'(v.sb));
        chk(v.name, "flush_if_id", 32'(flush_if_id), 32'(v.fie));
        chk(v.name, "flush_id_ex", 32'(flush_id_ex), 32'(v.fix));
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk_vec(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name          iv rs1 rs2 u1 u2 rd rw mr mq br rdy  fa     fb    sf sb fie fix
        vecs.push_back(mk("t1_add_x5",   1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t1_add_x6",   1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t1_mem_fwd",  1, 5, 3, 1, 1, 7, 1, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t1_wb_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_add_x5a",  1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_add_x5b",  1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_add_x8",   1, 5, 5, 1, 1, 8, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_mem_wins", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0));
        vecs.push_back(mk("t2_add_x0",   1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_add_x9",   1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_x0_mem",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t2_x0_wb",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t3_lw_x5",    1, 1, 0, 1, 0, 5, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t3_load_use", 1, 3, 5, 1, 1,10, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 1));
        vecs.push_back(mk("t3_bubble",   1, 3, 5, 1, 1,10, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t3_fwd_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk("t5_lw_x11",   1, 1, 0, 1, 0,11, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t5_branch",   1,11, 2, 1, 1,12, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1));
        vecs.push_back(mk("t5_killed",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t3_lw_x13",   1, 2, 0, 1, 0,13, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk("t3_use_rs1",  1,13, 0, 1, 0,14, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 1));
        vecs.push_back(mk("t3_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));

        rst = 1'b1;
        drive(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk_vec(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        chk("reset", "perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("reset", "perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Mem wait: EX operand forwarded from WB must stay put while frozen; branch deferred
        step(mk("t4_add_x20",   1, 0, 0, 0, 0,20, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        step(mk("t4_lw_x15",    1, 1, 0, 1, 0,15, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        step(mk("t4_add_x21",   1,20, 0, 1, 0,21, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        step(mk("t4_wait1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0, 0));
        step(mk("t4_wait2_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 1, 1, 0, 0));
        step(mk("t4_wait3_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 1, 1, 0, 0));
        step(mk("t4_release",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00, 0, 0, 1, 1));
        step(mk("t4_flowing",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));

        // Reset while frozen in MEM_WAIT
        step(mk("t6_lw_x17",    1, 1, 0, 1, 0,17, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        step(mk("t6_lw_in_ex",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        step(mk("t6_enter",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0));
        step(mk("t6_waiting",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        chk("t6_pre_rst", "perf_stall_cnt", perf_stall_cnt, 32'd6);
        chk("t6_pre_rst", "perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_vec(mk("t6_in_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        chk("t6_in_rst", "perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("t6_in_rst", "perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_vec(mk("t6_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        step(mk("t6_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
